// File: rtl/bit_pair_gen.sv
// Burst generator: emits len pairs (a,b) from an 8-bit Fibonacci LFSR, b optionally corrupted at one index.
// Optional abort input when BIT_PAIR_GEN_ABORT_EN is defined.
module bit_pair_gen #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] err_pos,
  input  logic       err_en,
`ifdef BIT_PAIR_GEN_ABORT_EN
  input  logic       abort,
`endif
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] lfsr_reg, lfsr_next;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] len_reg, len_next;
  logic [7:0] err_pos_reg, err_pos_next;
  logic       err_en_reg, err_en_next;
  logic       a_reg, a_next;
  logic       b_reg, b_next;
  logic       valid_reg, valid_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  // Low for the first edge after reset release so start is not accepted there.
  logic       armed_reg, armed_next;

  logic       fb;
  logic [7:0] last_idx;
  logic       inject;

  assign fb       = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign last_idx = len_reg - 8'd1;  // len 0 wraps to 255, i.e. a 256-pair burst
  assign inject   = err_en_reg && (idx_reg == err_pos_reg);

  always_comb begin
    state_next   = state_reg;
    lfsr_next    = lfsr_reg;
    idx_next     = idx_reg;
    len_next     = len_reg;
    err_pos_next = err_pos_reg;
    err_en_next  = err_en_reg;
    a_next       = 1'b0;
    b_next       = 1'b0;
    valid_next   = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    armed_next   = 1'b1;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        if (start && armed_reg) begin
          len_next     = len;
          err_pos_next = err_pos;
          err_en_next  = err_en;
          lfsr_next    = SEED;
          idx_next     = 8'd0;
          busy_next    = 1'b1;
          state_next   = RUN;
        end
      end
      RUN: begin
`ifdef BIT_PAIR_GEN_ABORT_EN
        if (abort) begin
          state_next = DONE;
        end else begin
`endif
          a_next     = lfsr_reg[7];
          b_next     = lfsr_reg[7] ^ inject;
          valid_next = 1'b1;
          lfsr_next  = {lfsr_reg[6:0], fb};
          idx_next   = idx_reg + 8'd1;
          if (idx_reg == last_idx) begin
            state_next = DONE;
          end
`ifdef BIT_PAIR_GEN_ABORT_EN
        end
`endif
      end
      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      lfsr_reg    <= SEED;
      idx_reg     <= 8'd0;
      len_reg     <= 8'd0;
      err_pos_reg <= 8'd0;
      err_en_reg  <= 1'b0;
      a_reg       <= 1'b0;
      b_reg       <= 1'b0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lfsr_reg    <= lfsr_next;
      idx_reg     <= idx_next;
      len_reg     <= len_next;
      err_pos_reg <= err_pos_next;
      err_en_reg  <= err_en_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      armed_reg   <= armed_next;
    end
  end

  assign a     = a_reg;
  assign b     = b_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: doc/bit_pair_gen.md
BIT_PAIR_GEN -- requirements
Module: bit_pair_gen

Interface
REQ-001 SHALL have parameter SEED, default 8'h01: LFSR load value, nonzero.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to transmit one burst; sampled only in IDLE.
REQ-005 SHALL have port len  input  8  number of bit pairs in the burst, latched on start; 0 means 256.
REQ-006 SHALL have port err_pos  input  8  pair index at which b is corrupted, latched on start.
REQ-007 SHALL have port err_en  input  1  enables single-bit corruption of b, latched on start.
REQ-008 SHALL have port a  output  1  reference stream bit.
REQ-009 SHALL have port b  output  1  companion stream bit; equals a except at the injected error.
REQ-010 SHALL have port valid  output  1  high when a/b carry a burst pair.
REQ-011 SHALL have port busy  output  1  high from start acceptance until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse after the last pair.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1 at edge E0: latch len/err_pos/err_en, load LFSR with SEED, clear pair index, enter RUN, and set busy=1 after E0.
REQ-015 SHALL use an 8-bit Fibonacci LFSR: fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}, advanced once per RUN cycle.
REQ-016 SHALL, on each RUN edge, register a=l[7], b=l[7]^(err_en_q && idx==err_pos_q), valid=1, then advance LFSR and idx (8-bit, wraps at 255->0).
REQ-017 SHALL make the first pair visible after E1 (the edge after E0), giving 2-edge start-to-data latency.
REQ-018 SHALL keep valid high for exactly len_q cycles (256 when len_q=0), with no gaps.
REQ-019 SHALL enter DONE on the edge that registers pair idx==len_q-1 (mod 256).
REQ-020 SHALL, in DONE, drive valid=0, a=0, b=0, done=1 for one cycle, then return to IDLE with busy=0.
REQ-021 SHALL drive a=0 and b=0 whenever valid=0.
REQ-022 SHALL ignore start outside IDLE; start held high continuously SHALL begin a new burst on the first IDLE cycle after DONE.
REQ-023 SHALL inject no error when err_pos_q >= effective length (err_pos_q >= len_q, with len_q != 0).
REQ-024 SHALL register every output; there is no combinational input-to-output path.

Reset
REQ-025 SHALL, on reset=0 at any time including mid-burst, immediately force the state to IDLE, LFSR=SEED, idx=0, latched fields=0, and a=b=valid=busy=done=0.
REQ-026 SHALL NOT accept start on the first edge after reset deasserts; acceptance begins on the second edge.

Configuration
REQ-027 SHALL, with BIT_PAIR_GEN_ABORT_EN defined, add port abort (input, 1): abort=1 in RUN SHALL enter DONE on the next edge (valid=0, done pulse), truncating the burst; abort SHALL be ignored in IDLE and DONE.
REQ-028 SHALL, without BIT_PAIR_GEN_ABORT_EN, have no abort port, and every burst SHALL run to full length.

Verification
REQ-029 SHALL cover: SEED=8'h01, len=8, err_en=0, start pulse -> valid high 8 cycles, a=b=0,0,0,0,0,0,0,1, then done one cycle, busy low after.
REQ-030 SHALL cover: len=8, err_en=1, err_pos=3 -> b differs from a only on the 4th valid pair.
REQ-031 SHALL cover: len=0 -> exactly 256 valid cycles, then a done pulse; err_pos=255 with err_en=1 -> error on the last pair only.
REQ-032 SHALL cover: start pulsed during RUN and DONE -> no restart, no length change; start held high -> back-to-back bursts separated by one DONE cycle plus one IDLE cycle.
REQ-033 SHALL cover: reset=0 asserted at pair 4 of len=20 -> all outputs 0 immediately; next burst restarts from the SEED sequence.
REQ-034 SHALL cover, with BIT_PAIR_GEN_ABORT_EN: abort at pair 5 of len=20 -> exactly 6 valid pairs, then a done pulse.
